// File: rtl/snn_fetch_pkg.sv
// Shared FSM encoding, width helpers and id flag for the synapse fetch sequencer.
package snn_fetch_pkg;

  typedef enum logic [1:0] {StIdle, StBias, StIssue} fetch_state_e;

  // MSB of the data id marks a bias burst.
  localparam logic BiasFlag = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  function automatic int unsigned id_width(input int unsigned n_neurons);
    return clog2(n_neurons) + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned words);
    return clog2(words);
  endfunction

endpackage

// File: rtl/spike_arbiter.sv
// Combinational grant over the pending spike vector.
// ROUND_ROBIN_EN selects round-robin from last_grant+1; otherwise lowest index wins.
module spike_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = 3
) (
  input  logic [N-1:0]    pending_i,
  input  logic [IdxW-1:0] last_grant_i,
  output logic            grant_valid_o,
  output logic [IdxW-1:0] grant_id_o
);

`ifdef ROUND_ROBIN_EN
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] sel;
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(last_grant_i) + 32'd1 + i;
      if (idx >= N) idx = idx - N;
      sel = IdxW'(idx);
      if (!grant_valid_o && pending_i[sel]) begin
        grant_valid_o = 1'b1;
        grant_id_o    = sel;
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;

  always_comb begin
    logic [IdxW-1:0] sel;
    grant_valid_o = |pending_i;
    grant_id_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sel = IdxW'(i);
      if (pending_i[sel]) grant_id_o = sel;
    end
  end
`endif

endmodule

// File: rtl/synapse_fetch_sequencer.sv
// Arbitrates neuron spike edges into WORDS-long weight read bursts, fetches the bias block at
// boot, and marks the returning read data. Build option: ROUND_ROBIN_EN (round-robin grant).
module synapse_fetch_sequencer
  import snn_fetch_pkg::*;
#(
  parameter int unsigned N_NEURONS   = 8,
  parameter int unsigned WORDS       = 15,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned BIAS_BASE   = N_NEURONS * WORDS,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         boot_mode,
  input  logic [N_NEURONS-1:0]         edge_detected,
  input  logic                         hold,
  output logic [ADDR_W-1:0]            addr,
  output logic                         addr_valid,
  output logic                         data_start,
  output logic                         data_done,
  output logic [clog2(N_NEURONS):0]    data_id,
  output logic                         busy
);

  localparam int unsigned IdxW = clog2(N_NEURONS);
  localparam int unsigned IdW  = id_width(N_NEURONS);
  localparam int unsigned CntW = cnt_width(WORDS);
  localparam logic [CntW-1:0]   LastCnt   = CntW'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BiasBaseA = ADDR_W'(BIAS_BASE);
  localparam logic [ADDR_W-1:0] WordsA    = ADDR_W'(WORDS);

  typedef struct packed {
    logic           valid;
    logic           first;
    logic           last;
    logic [IdW-1:0] id;
  } marker_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [N_NEURONS-1:0]  pending_q, pending_d, grant_clear;
  logic [IdxW-1:0]       last_grant_q, last_grant_d;
  logic                  boot_req_q, boot_req_d;
  logic                  boot_mode_q;
  marker_t               pipe_q [MEM_LATENCY];
  marker_t               pipe_d [MEM_LATENCY];

  logic                  arb_valid;
  logic [IdxW-1:0]       arb_id;
  logic                  active, issue, last_word, take_next, start_bias, start_neuron;

  spike_arbiter #(
    .N    (N_NEURONS),
    .IdxW (IdxW)
  ) u_spike_arbiter (
    .pending_i     (pending_q),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (arb_valid),
    .grant_id_o    (arb_id)
  );

  always_comb begin
    active       = (state_q != StIdle);
    issue        = active && !hold;
    last_word    = issue && (cnt_q == LastCnt);
    // A finishing burst hands straight over to the next grant, so bursts run without a bubble.
    take_next    = !active || last_word;
    start_bias   = take_next && boot_req_q && boot_mode;
    start_neuron = take_next && !start_bias && !boot_mode && arb_valid;

    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    grant_clear  = '0;
    boot_req_d   = boot_req_q | (boot_mode_q & ~boot_mode);

    if (issue) cnt_d = last_word ? '0 : cnt_q + CntW'(1);
    if (last_word) state_d = StIdle;

    if (start_bias) begin
      state_d    = StBias;
      base_d     = BiasBaseA;
      cnt_d      = '0;
      id_d       = {BiasFlag, {IdxW{1'b0}}};
      boot_req_d = 1'b0;
    end else if (start_neuron) begin
      state_d             = StIssue;
      base_d              = ADDR_W'(arb_id) * WordsA;
      cnt_d               = '0;
      id_d                = {1'b0, arb_id};
      grant_clear[arb_id] = 1'b1;
      last_grant_d        = arb_id;
    end

    // Set wins over clear so a re-spike in the grant cycle queues another burst.
    pending_d = (pending_q & ~grant_clear) | edge_detected;

    pipe_d[0] = '{valid: issue,
                  first: issue && (cnt_q == '0),
                  last:  last_word,
                  id:    issue ? id_q : '0};
    for (int i = 1; i < MEM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      pending_q    <= '0;
      last_grant_q <= IdxW'(N_NEURONS - 1);
      boot_req_q   <= 1'b1;
      boot_mode_q  <= 1'b0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      boot_req_q   <= boot_req_d;
      boot_mode_q  <= boot_mode;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    addr_valid = issue;
    addr       = active ? base_q + ADDR_W'(cnt_q) : '0;
    data_start = pipe_q[MEM_LATENCY-1].valid & pipe_q[MEM_LATENCY-1].first;
    data_done  = pipe_q[MEM_LATENCY-1].valid & pipe_q[MEM_LATENCY-1].last;
    data_id    = pipe_q[MEM_LATENCY-1].valid ? pipe_q[MEM_LATENCY-1].id : '0;
    busy       = active;
    for (int i = 0; i < MEM_LATENCY; i++) busy = busy | pipe_q[i].valid;
  end

endmodule

// File: tb/tb_synapse_fetch_sequencer.sv
// Bench for synapse_fetch_sequencer: burst-level vector table, hand-written corner cases and
// a randomized run checked cycle by cycle against a behavioural reference model.
module tb_synapse_fetch_sequencer;

  localparam int N  = 8;
  localparam int W  = 15;
  localparam int AW = 10;
  localparam int BB = 120;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          boot_mode;
  logic [N-1:0]  edge_detected;
  logic          hold;
  logic [AW-1:0] addr;
  logic          addr_valid, data_start, data_done, busy;
  logic [3:0]    data_id;

  synapse_fetch_sequencer #(
    .N_NEURONS   (N),
    .WORDS       (W),
    .ADDR_W      (AW),
    .BIAS_BASE   (BB),
    .MEM_LATENCY (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .boot_mode     (boot_mode),
    .edge_detected (edge_detected),
    .hold          (hold),
    .addr          (addr),
    .addr_valid    (addr_valid),
    .data_start    (data_start),
    .data_done     (data_done),
    .data_id       (data_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a burst is an owner (-1 = bias) plus a word index.
  typedef struct {bit valid; bit first; bit last; int id;} mark_t;
  bit [N-1:0] m_pend;
  bit         m_active;
  int         m_owner, m_idx, m_last;
  bit         m_armed, m_prev_boot;
  mark_t      m_q[$];

  int obs_addr[$];
  int obs_cyc[$];
  int obs_id[$];
  int obs_done;

  typedef struct {
    logic       boot;
    logic [7:0] edges;
    logic [7:0] edges_next;
    int         n;
    int         base0, id0, base1, id1;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int base_of(int owner);
    return owner < 0 ? BB : owner * W;
  endfunction

  function automatic int pick();
    int start;
`ifdef ROUND_ROBIN_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) if (m_pend[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_active = 0; m_owner = 0; m_idx = 0;
    m_armed = 1; m_prev_boot = 0; m_last = N - 1;
    m_q.delete();
    for (int i = 0; i < L; i++) m_q.push_back('{0, 0, 0, 0});
  endtask

  function automatic logic [AW+7:0] model_out();
    bit v, b;
    logic [AW-1:0] a;
    mark_t h;
    v = m_active && !hold;
    a = m_active ? AW'(base_of(m_owner) + m_idx) : '0;
    h = m_q[0];
    b = m_active;
    foreach (m_q[k]) if (m_q[k].valid) b = 1;
    return {v, a, h.valid && h.first, h.valid && h.last, h.valid ? 4'(h.id) : 4'd0, b};
  endfunction

  task automatic model_step();
    bit v;
    int p;
    mark_t cur;
    v   = m_active && !hold;
    cur = '{v, v && m_idx == 0, v && m_idx == W - 1, m_owner < 0 ? 8 : m_owner};
    void'(m_q.pop_front());
    m_q.push_back(cur);
    if (v) begin
      m_idx++;
      if (m_idx == W) m_active = 0;
    end
    if (!m_active) begin
      if (m_armed && boot_mode) begin
        m_active = 1; m_owner = -1; m_idx = 0; m_armed = 0;
      end else if (!boot_mode) begin
        p = pick();
        if (p >= 0) begin
          m_active = 1; m_owner = p; m_idx = 0; m_pend[p] = 0; m_last = p;
        end
      end
    end
    m_pend = m_pend | edge_detected;
    if (m_prev_boot && !boot_mode) m_armed = 1;
    m_prev_boot = boot_mode;
  endtask

  function automatic bit model_quiet();
    bit q;
    q = !m_active && (m_pend == '0);
    foreach (m_q[k]) if (m_q[k].valid) q = 0;
    return q;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check("cycle", {addr_valid, addr, data_start, data_done, data_id, busy}, model_out());
    if (addr_valid) begin
      obs_addr.push_back(int'(addr));
      obs_cyc.push_back(cyc);
    end
    if (data_start) obs_id.push_back(int'(data_id));
    if (data_done) obs_done++;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic obs_clear();
    obs_addr.delete(); obs_cyc.delete(); obs_id.delete(); obs_done = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!model_quiet() && n < 400) begin
      tick();
      n++;
    end
    repeat (L + 1) tick();
    check("idle busy", busy, 0);
  endtask

  task automatic run_vector(input vec_t v);
    int last;
    obs_clear();
    boot_mode = v.boot;
    edge_detected = v.edges;
    tick();
    edge_detected = v.edges_next;
    tick();
    edge_detected = '0;
    drain();
    check("burst count", obs_id.size(), v.n);
    check("done count", obs_done, v.n);
    check("addr count", obs_addr.size(), v.n * W);
    if (obs_addr.size() == v.n * W) begin
      last = obs_addr.size() - 1;
      check("first addr", obs_addr[0], v.base0);
      check("end of burst0", obs_addr[W-1], v.base0 + W - 1);
      check("no bubble", obs_cyc[last] - obs_cyc[0] + 1, v.n * W);
      if (v.n == 2) check("second base", obs_addr[W], v.base1);
    end
    if (obs_id.size() >= 1) check("id0", obs_id[0], v.id0);
    if (obs_id.size() >= 2 && v.n == 2) check("id1", obs_id[1], v.id1);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'h00, 8'h00, 1, 120, 8, 0, 0};
    vecs[1] = '{1'b0, 8'h04, 8'h00, 1, 30, 2, 0, 0};
`ifdef ROUND_ROBIN_EN
    vecs[2] = '{1'b0, 8'h81, 8'h00, 2, 105, 7, 0, 0};
`else
    vecs[2] = '{1'b0, 8'h81, 8'h00, 2, 0, 0, 105, 7};
`endif
    vecs[3] = '{1'b0, 8'h60, 8'h00, 2, 75, 5, 90, 6};
    vecs[4] = '{1'b0, 8'h08, 8'h08, 2, 45, 3, 45, 3};   // re-spike in the grant cycle
    vecs[5] = '{1'b0, 8'h05, 8'h04, 2, 0, 0, 30, 2};    // repeat edge merges while pending

    rst = 1'b1; boot_mode = 1'b1; hold = 1'b0; edge_detected = '0;
    obs_clear();
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", {addr_valid, addr, data_start, data_done, data_id, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    foreach (vecs[i]) run_vector(vecs[i]);

    // Hold at word 5 of neuron 1.
    obs_clear();
    boot_mode = 1'b0;
    edge_detected = 8'h02;
    tick();
    edge_detected = '0;
    n = 0;
    while (!(addr_valid && addr == 10'd20) && n < 40) begin
      tick();
      n++;
    end
    check("reach addr 20", {addr_valid, addr}, {1'b1, 10'd20});
    hold = 1'b1;
    repeat (3) begin
      #1;
      check("hold valid", addr_valid, 0);
      check("hold addr", addr, 20);
      tick();
    end
    hold = 1'b0;
    #1;
    check("resume addr", {addr_valid, addr}, {1'b1, 10'd20});
    drain();
    check("hold addr count", obs_addr.size(), W);
    if (obs_addr.size() > 0) check("hold last addr", obs_addr[obs_addr.size()-1], 29);

    // Reset mid-burst of neuron 4 with neuron 5 still pending.
    edge_detected = 8'h10;
    tick();
    edge_detected = 8'h20;
    tick();
    edge_detected = '0;
    n = 0;
    while (!(addr_valid && addr == 10'd67) && n < 40) begin
      tick();
      n++;
    end
    check("reach addr 67", {addr_valid, addr}, {1'b1, 10'd67});
    #2 rst = 1'b1;
    #1;
    check("async reset", {addr_valid, addr, data_start, data_done, data_id, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_clear();
    repeat (40) tick();
    check("no addr after reset", obs_addr.size(), 0);
    check("no done after reset", obs_done, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      edge_detected = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 19) == 0) edge_detected[i] = 1'b1;
      hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) boot_mode = ~boot_mode;
      tick();
    end
    boot_mode = 1'b0; hold = 1'b0; edge_detected = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
